// File: rtl/uart_loader.sv
// uart_loader: serial program loader feeding the core's instruction/data BRAM.
// It receives 8N1 bytes on rxd. The first 4 bytes are a little-endian word
// count N. The N little-endian 32-bit words that follow are written to BRAM
// from word address 0 upward, and done is raised when the last word is in.
// Optional feature: define UART_LOADER_ACK_EN to send a single 0xAA acknowledge
// byte on txd when the load completes. When it is undefined, txd is tied high.
module uart_loader #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int ADDR_W           = 20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rxd,
    output logic              txd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int FULL_BIT = 2 * CLK_PER_HALF_BIT;
    localparam int CNT_W    = $clog2(FULL_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(FULL_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {LD_LEN, LD_DATA, LD_DONE} ld_state_e;

    // Synchronizer and receiver state
    logic             rxd_s1_q, rxd_s2_q, rxd_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_vld_q, byte_vld_d;
    logic             start_acc;
    logic             stop_bad;

    // Loader state
    ld_state_e        ld_state_q, ld_state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      len_q, len_d;
    logic [23:0]      word_q, word_d;
    logic [31:0]      word_cnt_q, word_cnt_d;
    logic             mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             frame_err_q, frame_err_d;
    logic [31:0]      len_full;

    // Receiver next-state: start-bit glitch check, mid-bit sampling, stop check
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_vld_d = 1'b0;
        start_acc  = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rxd_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                        start_acc  = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == FULL_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == FULL_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rxd_s2_q) begin
                        byte_vld_d = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // The length value as it stands once the current byte is merged in
    always_comb begin
        len_full = len_q;
        len_full[{byte_idx_q, 3'b000} +: 8] = rx_shift_q;
    end

    // Loader next-state: length field, word assembly, BRAM write, completion
    always_comb begin
        ld_state_d  = ld_state_q;
        byte_idx_d  = byte_idx_q;
        len_d       = len_q;
        word_d      = word_q;
        word_cnt_d  = word_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        frame_err_d = frame_err_q;

        if (ld_state_q != LD_DONE) begin
            if (start_acc) busy_d = 1'b1;
            if (stop_bad) frame_err_d = 1'b1;
        end

        case (ld_state_q)
            LD_LEN: begin
                if (byte_vld_q) begin
                    len_d      = len_full;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        if (len_full == 32'd0) begin
                            ld_state_d = LD_DONE;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                        end else begin
                            ld_state_d = LD_DATA;
                        end
                    end
                end
            end
            LD_DATA: begin
                // The counter has already been bumped by the write in flight.
                if (mem_we_q && (word_cnt_q == len_q)) begin
                    ld_state_d = LD_DONE;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end else if (byte_vld_q) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        mem_wdata_d = {rx_shift_q, word_q};
                        word_cnt_d  = word_cnt_q + 32'd1;
                    end else begin
                        word_d[{byte_idx_q, 3'b000} +: 8] = rx_shift_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // State registers for the synchronizer, receiver and loader
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_s1_q    <= 1'b1;
            rxd_s2_q    <= 1'b1;
            rxd_prev_q  <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            byte_vld_q  <= 1'b0;
            ld_state_q  <= LD_LEN;
            byte_idx_q  <= '0;
            len_q       <= '0;
            word_q      <= '0;
            word_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            rxd_s1_q    <= rxd;
            rxd_s2_q    <= rxd_s1_q;
            rxd_prev_q  <= rxd_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            byte_vld_q  <= byte_vld_d;
            ld_state_q  <= ld_state_d;
            byte_idx_q  <= byte_idx_d;
            len_q       <= len_d;
            word_q      <= word_d;
            word_cnt_q  <= word_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;

`ifdef UART_LOADER_ACK_EN
    // Frame sent LSB first: start 0, data 0xAA, stop 1
    localparam logic [9:0] ACK_FRAME = {1'b1, 8'hAA, 1'b0};

    logic             tx_busy_q, tx_busy_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic             txd_q, txd_d;

    // Acknowledge transmitter: launched once, on the transition into LD_DONE
    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        txd_d     = txd_q;
        if (ld_state_q != LD_DONE && ld_state_d == LD_DONE) begin
            tx_busy_d = 1'b1;
            tx_cnt_d  = '0;
            tx_bit_d  = '0;
            txd_d     = ACK_FRAME[0];
        end else if (tx_busy_q) begin
            if (tx_cnt_q == FULL_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    txd_d     = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    txd_d    = ACK_FRAME[tx_bit_q + 4'd1];
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    // Transmitter registers; txd idles high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            txd_q     <= 1'b1;
        end else begin
            tx_busy_q <= tx_busy_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            txd_q     <= txd_d;
        end
    end

    assign txd = txd_q;
`else
    assign txd = 1'b1;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: bytes are driven serially on rxd and
// the expected BRAM writes are queued in a scoreboard as each word is sent.
// A small ADDR_W is used so that address wrap-around can be exercised.
module tb_uart_loader;

    localparam int HALF   = 8;
    localparam int AW     = 2;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = 2 * HALF * CLK_NS;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rxd = 1'b1;
    logic          txd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, done, frame_err;

    uart_loader #(.CLK_PER_HALF_BIT(HALF), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #(CLK_NS / 2) clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  wr_count = 0;
    int  last_we_cyc = 0;
    int  done_rise_cyc = 0;
    logic prev_we = 1'b0;
    logic prev_done = 1'b0;
    logic txd_low_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: pops the scoreboard on each write
    always @(negedge clk) begin
        if (mem_we) begin
            wr_count++;
            last_we_cyc = cyc;
            if (prev_we) check("we_back_to_back", 1, 0);
            if (sb.size() == 0) begin
                check("spurious_write", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
            end
        end
        if (done && !prev_done) done_rise_cyc = cyc;
        if (rstn && !txd) txd_low_seen = 1'b1;
        prev_we = mem_we;
        prev_done = done;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
        rxd = stop_bit;
        #(BIT_NS);
        rxd = 1'b1;
        if (!stop_bit) #(BIT_NS);
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic send_word(input int addr, input logic [31:0] w);
        wr_t e;
        e.addr = AW'(addr);
        e.data = w;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_txd"}, txd, 1);
    endtask

    task automatic do_reset();
        rxd = 1'b1;
        rstn = 1'b0;
        #(3 * CLK_NS + 2);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        #(2 * BIT_NS);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 8 * 2 * HALF) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic end_of_load(input string tag, input logic exp_ferr);
        wait_done({tag, "_done"});
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_ferr"}, frame_err, exp_ferr);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int base;
        #(2 * CLK_NS + 3);
        check_reset_outputs("por");
        @(negedge clk);
        rstn = 1'b1;
        #(2 * BIT_NS);

        // Two-word load with done timing
        base = wr_count;
        send_byte(8'h02);
        check("t1_busy_mid", busy, 1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(0, 32'h11223344);
        send_word(1, 32'hDEADBEEF);
        end_of_load("t1", 1'b0);
        check("t1_writes", wr_count - base, 2);
        check("t1_done_lag", done_rise_cyc - last_we_cyc, 1);
`ifdef UART_LOADER_ACK_EN
        begin
            int n = 0;
            logic [7:0] ack;
            while (txd && n < 4 * 2 * HALF) begin
                @(negedge clk);
                n++;
            end
            check("ack_start_seen", txd, 0);
            repeat (HALF) @(negedge clk);
            check("ack_start_mid", txd, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (2 * HALF) @(negedge clk);
                ack[i] = txd;
            end
            check("ack_byte", ack, 8'hAA);
            repeat (2 * HALF) @(negedge clk);
            check("ack_stop", txd, 1);
        end
`endif

        // Zero-length load, then trailing bytes must be ignored
        do_reset();
        base = wr_count;
        send_len(32'd0);
        end_of_load("t2", 1'b0);
        send_byte(8'h55);
        send_byte(8'h01);
        check("t2_writes", wr_count - base, 0);
        check("t2_done_sticky", done, 1);
        check("t2_busy_ignored", busy, 0);

        // Short glitch on rxd must not start a byte
        do_reset();
        rxd = 1'b0;
        #(BIT_NS * 3 / 10);
        rxd = 1'b1;
        #(2 * BIT_NS);
        check("t3_glitch_busy", busy, 0);
        base = wr_count;
        send_len(32'd1);
        send_word(0, 32'hCAFEF00D);
        end_of_load("t3", 1'b0);
        check("t3_writes", wr_count - base, 1);

        // Bad stop on third data byte: byte lost, an extra byte completes the word
        do_reset();
        begin
            wr_t e;
            e.addr = '0;
            e.data = 32'h77CAF00D;
            sb.push_back(e);
        end
        send_len(32'd1);
        send_byte(8'h0D);
        send_byte(8'hF0);
        send_byte(8'hFE, 1'b0);
        check("t4_ferr_set", frame_err, 1);
        check("t4_not_done", done, 0);
        send_byte(8'hCA);
        send_byte(8'h77);
        end_of_load("t4", 1'b1);

        // Reset after 5 of 12 bytes, then the full stream again
        do_reset();
        send_len(32'd2);
        send_byte(8'h44);
        rstn = 1'b0;
        #(CLK_NS + 1);
        check_reset_outputs("t5_rst");
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        #(2 * BIT_NS);
        base = wr_count;
        send_len(32'd2);
        send_word(0, 32'h11223344);
        send_word(1, 32'hDEADBEEF);
        end_of_load("t5", 1'b0);
        check("t5_writes", wr_count - base, 2);

        // More words than addresses: the address wraps
        do_reset();
        base = wr_count;
        send_len(32'd5);
        for (int i = 0; i < 5; i++) send_word(i % (1 << AW), 32'hA5000000 + i * 32'h01010101);
        end_of_load("t6", 1'b0);
        check("t6_writes", wr_count - base, 5);

`ifndef UART_LOADER_ACK_EN
        check("txd_always_high", txd_low_seen, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
